// File: rtl/led_scroll_scheduler_pkg.sv
`default_nettype none
// ============================================================================
// Module : led_sched_pkg
// Shared state encoding, display constants and width helper.
// Rev    : 1.0
// ============================================================================
package led_sched_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHOW   = 2'd1,
        SCROLL = 2'd2,
        ERR    = 2'd3
    } sched_state_t;

    localparam logic [15:0] ERR_PATTERN = 16'hEEEE;
    localparam logic [15:0] BLANK       = 16'h0000;

    // Minimum one bit so degenerate widths never collapse to zero.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r = r + 1;
        return (r < 1) ? 1 : r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/led_scroll_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module : led_scroll_scheduler_if
// UART-receive strobes in, display window and buffer status out.
// Rev    : 1.0
// ============================================================================
interface led_scroll_scheduler_if #(
    parameter int DEPTH = 8
);
    import led_sched_pkg::*;

    localparam int CW = clog2(2 * DEPTH) + 1;

    logic          Rx_VALID;
    logic [7:0]    Rx_DATA;
    logic          Rx_ERROR;
    logic          clear;
    logic [15:0]   digits;
    logic          digits_valid;
    logic [CW-1:0] buf_count;
    logic          overflow;

    modport master (
        output Rx_VALID, Rx_DATA, Rx_ERROR, clear,
        input  digits, digits_valid, buf_count, overflow
    );

    modport slave (
        input  Rx_VALID, Rx_DATA, Rx_ERROR, clear,
        output digits, digits_valid, buf_count, overflow
    );

endinterface
`default_nettype wire

// File: rtl/led_scroll_scheduler_nibble_ring_buffer.sv
`default_nettype none
// ============================================================================
// Module : nibble_ring_buffer
// Circular nibble store written a byte at a time; reads see post-write data.
// Rev    : 1.0
// ============================================================================
module nibble_ring_buffer
    import led_sched_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 i_clear,
    input  logic                                 i_wr,
    input  logic [7:0]                           i_byte,
    input  logic [3:0][clog2(2*DEPTH)-1:0]       i_rd_idx,
    output logic [3:0][3:0]                      o_rd_nib,
    output logic [clog2(2*DEPTH):0]              o_count,
    output logic [clog2(2*DEPTH):0]              o_count_next,
    output logic                                 o_overflow
);
    localparam int NIB = 2 * DEPTH;
    localparam int IW  = clog2(NIB);
    localparam int CW  = IW + 1;

    logic [3:0]    r_mem [NIB];
    logic [IW-1:0] r_wp;
    logic [CW-1:0] r_count;
    logic          r_overflow;

    logic [3:0]    w_mem_n [NIB];
    logic [IW-1:0] w_wp_n;
    logic [CW-1:0] w_count_n;
    logic          w_ovf_n;
    logic [CW:0]   w_sum;
    logic [IW-1:0] w_phys;

    always_comb begin
        w_mem_n   = r_mem;
        w_wp_n    = r_wp;
        w_count_n = r_count;
        w_ovf_n   = r_overflow;
        w_sum     = {1'b0, r_count} + (CW+1)'(2);
        if (i_clear) begin
            w_wp_n    = '0;
            w_count_n = '0;
            w_ovf_n   = 1'b0;
        end else if (i_wr) begin
            w_mem_n[r_wp]          = i_byte[7:4];
            w_mem_n[r_wp + IW'(1)] = i_byte[3:0];
            w_wp_n                 = r_wp + IW'(2);
            if (w_sum > (CW+1)'(NIB)) begin
                w_count_n = CW'(NIB);
                w_ovf_n   = 1'b1;
            end else begin
                w_count_n = w_sum[CW-1:0];
            end
        end
    end

    // Oldest entry sits count slots behind the write pointer; at full count
    // the low IW bits are zero, so the oldest is the write pointer itself.
    always_comb begin
        w_phys   = '0;
        o_rd_nib = '0;
        for (int k = 0; k < 4; k++) begin
            w_phys      = w_wp_n - w_count_n[IW-1:0] + i_rd_idx[k];
            o_rd_nib[k] = w_mem_n[w_phys];
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < NIB; i++) r_mem[i] <= 4'h0;
            r_wp       <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            r_mem      <= w_mem_n;
            r_wp       <= w_wp_n;
            r_count    <= w_count_n;
            r_overflow <= w_ovf_n;
        end
    end

    assign o_count      = r_count;
    assign o_count_next = w_count_n;
    assign o_overflow   = r_overflow;

endmodule
`default_nettype wire

// File: rtl/led_scroll_scheduler.sv
`default_nettype none
// ============================================================================
// Module : led_scroll_scheduler
// Chooses the four displayed nibbles: static, scrolling window or error hold.
// Rev    : 1.0
// ============================================================================
module led_scroll_scheduler
    import led_sched_pkg::*;
#(
    parameter int DEPTH       = 8,
    parameter int STEP_CYCLES = 2500000,
    parameter int ERR_HOLD    = 5000000
) (
    input  logic                 clk,
    input  logic                 reset,
    led_scroll_scheduler_if.slave bus
);
    localparam int NIB = 2 * DEPTH;
    localparam int IW  = clog2(NIB);
    localparam int CW  = IW + 1;
    localparam int TW  = clog2(STEP_CYCLES);
    localparam int HW  = clog2(ERR_HOLD + 1);

    sched_state_t  r_state, w_state_n, w_mode;
    logic [IW-1:0] r_ws, w_ws_n;
    logic [TW-1:0] r_timer, w_timer_n;
    logic [HW-1:0] r_hold, w_hold_n;
    logic [15:0]   r_digits, w_digits_n;
    logic          r_valid;

    logic [CW-1:0] w_cnt, w_cnt_n;
    logic          w_ovf;
    logic [CW-1:0] w_ws_inc, w_ws_wrap, w_sum;
    logic [3:0][IW-1:0] w_idx;
    logic [3:0][3:0]    w_nib;

    nibble_ring_buffer #(.DEPTH(DEPTH)) u_ring (
        .clk          (clk),
        .reset        (reset),
        .i_clear      (bus.clear),
        .i_wr         (bus.Rx_VALID),
        .i_byte       (bus.Rx_DATA),
        .i_rd_idx     (w_idx),
        .o_rd_nib     (w_nib),
        .o_count      (w_cnt),
        .o_count_next (w_cnt_n),
        .o_overflow   (w_ovf)
    );

    always_comb begin
        w_state_n = r_state;
        w_ws_n    = r_ws;
        w_timer_n = r_timer;
        w_hold_n  = r_hold;
        w_ws_inc  = {1'b0, r_ws} + CW'(1);
        w_ws_wrap = (w_ws_inc >= w_cnt_n) ? (w_ws_inc - w_cnt_n) : w_ws_inc;
        if (w_cnt_n == '0)            w_mode = IDLE;
        else if (w_cnt_n <= CW'(4))   w_mode = SHOW;
        else                          w_mode = SCROLL;

        if (bus.clear) begin
            w_state_n = IDLE;
            w_ws_n    = '0;
            w_timer_n = '0;
            w_hold_n  = '0;
        end else if (bus.Rx_ERROR) begin
            w_state_n = ERR;
            w_hold_n  = HW'(1);
        end else if (r_state == ERR && r_hold != HW'(ERR_HOLD)) begin
            w_hold_n  = r_hold + HW'(1);
        end else begin
            w_state_n = w_mode;
            w_hold_n  = '0;
            // Window keeps its phase through an error hold; only a fresh
            // transition from the static view restarts it.
            if (w_mode == SCROLL && (r_state == SCROLL || r_state == ERR)) begin
                if (r_timer == TW'(STEP_CYCLES - 1)) begin
                    w_timer_n = '0;
                    w_ws_n    = w_ws_wrap[IW-1:0];
                end else begin
                    w_timer_n = r_timer + TW'(1);
                end
            end else begin
                w_ws_n    = '0;
                w_timer_n = '0;
            end
        end
    end

    always_comb begin
        w_sum = '0;
        w_idx = '0;
        for (int k = 0; k < 4; k++) begin
            w_sum = {1'b0, w_ws_n} + CW'(3 - k);
            if (w_state_n == SHOW)
                w_idx[k] = IW'(w_cnt_n - CW'(k + 1));
            else if (w_sum >= w_cnt_n)
                w_idx[k] = IW'(w_sum - w_cnt_n);
            else
                w_idx[k] = w_sum[IW-1:0];
        end
    end

    always_comb begin
        w_digits_n = BLANK;
        case (w_state_n)
            ERR:    w_digits_n = ERR_PATTERN;
            SHOW: begin
                for (int k = 0; k < 4; k++)
                    if (CW'(k) < w_cnt_n) w_digits_n[4*k +: 4] = w_nib[k];
            end
            SCROLL: w_digits_n = w_nib;
            default: w_digits_n = BLANK;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state  <= IDLE;
            r_ws     <= '0;
            r_timer  <= '0;
            r_hold   <= '0;
            r_digits <= BLANK;
            r_valid  <= 1'b0;
        end else begin
            r_state  <= w_state_n;
            r_ws     <= w_ws_n;
            r_timer  <= w_timer_n;
            r_hold   <= w_hold_n;
            r_digits <= w_digits_n;
            r_valid  <= (w_digits_n != r_digits);
        end
    end

    assign bus.digits       = r_digits;
    assign bus.digits_valid = r_valid;
    assign bus.buf_count    = w_cnt;
    assign bus.overflow     = w_ovf;

endmodule
`default_nettype wire

// File: tb/tb_led_scroll_scheduler.sv
`default_nettype none
// ============================================================================
// Module : tb_led_scroll_scheduler
// Directed plus random stimulus against a queue-based display model.
// Rev    : 1.0
// ============================================================================
module tb_led_scroll_scheduler;

    localparam int DEPTH       = 4;
    localparam int NIB         = 2 * DEPTH;
    localparam int STEP_CYCLES = 4;
    localparam int ERR_HOLD    = 6;

    typedef enum int {M_IDLE, M_SHOW, M_SCROLL, M_ERR} mstate_t;

    logic clk;
    logic reset;
    int   n_total;
    int   n_pass;

    led_scroll_scheduler_if #(.DEPTH(DEPTH)) bus_if ();

    led_scroll_scheduler #(
        .DEPTH       (DEPTH),
        .STEP_CYCLES (STEP_CYCLES),
        .ERR_HOLD    (ERR_HOLD)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned m_q[$];
    mstate_t     m_st;
    int          m_ws, m_tmr, m_hold;
    bit          m_ovf, m_valid;
    logic [15:0] m_digits;

    function automatic logic [15:0] m_view();
        logic [15:0] v;
        int n;
        v = 16'h0000;
        n = m_q.size();
        case (m_st)
            M_ERR:    v = 16'hEEEE;
            M_SHOW:   for (int k = 0; k < 4; k++) if (k < n) v[4*k +: 4] = 4'(m_q[n-1-k]);
            M_SCROLL: for (int j = 0; j < 4; j++) v[4*(3-j) +: 4] = 4'(m_q[(m_ws + j) % n]);
            default:  v = 16'h0000;
        endcase
        return v;
    endfunction

    task automatic model_reset();
        m_q.delete();
        m_st = M_IDLE; m_ws = 0; m_tmr = 0; m_hold = 0;
        m_ovf = 1'b0; m_valid = 1'b0; m_digits = 16'h0000;
    endtask

    task automatic model_edge(input bit clr, input bit v, input logic [7:0] d, input bit e);
        mstate_t     prev;
        logic [15:0] nd;
        if (clr) begin
            m_q.delete();
            m_ovf = 1'b0; m_ws = 0; m_tmr = 0; m_st = M_IDLE;
        end else begin
            if (v) begin
                m_q.push_back(int'(d[7:4]));
                m_q.push_back(int'(d[3:0]));
                while (m_q.size() > NIB) begin
                    void'(m_q.pop_front());
                    m_ovf = 1'b1;
                end
            end
            if (e) begin
                m_st = M_ERR; m_hold = ERR_HOLD;
            end else if (m_st == M_ERR && m_hold > 1) begin
                m_hold--;
            end else begin
                prev = m_st;
                if (m_q.size() == 0)      m_st = M_IDLE;
                else if (m_q.size() <= 4) m_st = M_SHOW;
                else                      m_st = M_SCROLL;
                if (m_st == M_SCROLL && (prev == M_SCROLL || prev == M_ERR)) begin
                    m_tmr++;
                    if (m_tmr == STEP_CYCLES) begin
                        m_tmr = 0;
                        m_ws  = (m_ws + 1) % m_q.size();
                    end
                end else begin
                    m_ws = 0; m_tmr = 0;
                end
            end
        end
        nd       = m_view();
        m_valid  = (nd != m_digits);
        m_digits = nd;
    endtask

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_total++;
        assert (got === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, got, exp);
    endtask

    task automatic check_model();
        chk("digits", bus_if.digits, m_digits);
        chk("digits_valid", {15'b0, bus_if.digits_valid}, {15'b0, m_valid});
        chk("buf_count", {12'b0, bus_if.buf_count}, 16'(m_q.size()));
        chk("overflow", {15'b0, bus_if.overflow}, {15'b0, m_ovf});
    endtask

    task automatic cyc(input bit clr, input bit v, input logic [7:0] d, input bit e);
        bus_if.clear    = clr;
        bus_if.Rx_VALID = v;
        bus_if.Rx_DATA  = d;
        bus_if.Rx_ERROR = e;
        @(posedge clk);
        model_edge(clr, v, d, e);
        #1;
        bus_if.clear    = 1'b0;
        bus_if.Rx_VALID = 1'b0;
        bus_if.Rx_DATA  = 8'h00;
        bus_if.Rx_ERROR = 1'b0;
        check_model();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 8'h00, 1'b0);
    endtask

    task automatic rst_cyc();
        reset = 1'b0;
        @(posedge clk);
        model_reset();
        #1;
        check_model();
        chk("rst_digits", bus_if.digits, 16'h0000);
        chk("rst_count", {12'b0, bus_if.buf_count}, 16'h0000);
        chk("rst_ovf_valid", {14'b0, bus_if.overflow, bus_if.digits_valid}, 16'h0000);
    endtask

    bit          r_c, r_v, r_e;
    logic [7:0]  r_d;

    initial begin
        n_total = 0;
        n_pass  = 0;
        reset   = 1'b0;
        bus_if.clear    = 1'b0;
        bus_if.Rx_VALID = 1'b0;
        bus_if.Rx_DATA  = 8'h00;
        bus_if.Rx_ERROR = 1'b0;
        model_reset();

        rst_cyc();
        rst_cyc();
        reset = 1'b1;

        // Single byte: right-aligned static view, one change pulse.
        cyc(1'b0, 1'b1, 8'h3A, 1'b0);
        chk("show_3A", bus_if.digits, 16'h003A);
        chk("show_3A_valid", {15'b0, bus_if.digits_valid}, 16'h0001);
        idle(1);
        chk("show_3A_valid_drop", {15'b0, bus_if.digits_valid}, 16'h0000);

        // Three bytes into an empty buffer, then watch the window wrap.
        cyc(1'b1, 1'b0, 8'h00, 1'b0);
        cyc(1'b0, 1'b1, 8'h12, 1'b0);
        cyc(1'b0, 1'b1, 8'h34, 1'b0);
        cyc(1'b0, 1'b1, 8'h56, 1'b0);
        chk("scroll_entry", bus_if.digits, 16'h1234);
        idle(4);
        chk("scroll_1", bus_if.digits, 16'h2345);

        // Error hold from the 2345 window, then restore.
        for (int i = 0; i < ERR_HOLD; i++) begin
            cyc(1'b0, 1'b0, 8'h00, (i == 0));
            chk("err_hold", bus_if.digits, 16'hEEEE);
        end
        idle(1);
        chk("err_restore", bus_if.digits, 16'h2345);
        idle(3);
        chk("scroll_2", bus_if.digits, 16'h3456);
        idle(4);
        chk("scroll_3", bus_if.digits, 16'h4561);
        idle(4);
        chk("scroll_wrap", bus_if.digits, 16'h5612);

        // Re-triggered error: nine cycles of the pattern in total.
        for (int i = 0; i < 9; i++) begin
            cyc(1'b0, 1'b0, 8'h00, (i == 0 || i == 3));
            chk("err_extend", bus_if.digits, 16'hEEEE);
        end
        idle(1);
        chk("err_extend_exit", {15'b0, (bus_if.digits == 16'hEEEE)}, 16'h0000);

        // Overwrite of unread data.
        cyc(1'b1, 1'b0, 8'h00, 1'b0);
        cyc(1'b0, 1'b1, 8'h11, 1'b0);
        cyc(1'b0, 1'b1, 8'h22, 1'b0);
        cyc(1'b0, 1'b1, 8'h33, 1'b0);
        cyc(1'b0, 1'b1, 8'h44, 1'b0);
        cyc(1'b0, 1'b1, 8'h55, 1'b0);
        chk("ovf_count", {12'b0, bus_if.buf_count}, 16'd8);
        chk("ovf_flag", {15'b0, bus_if.overflow}, 16'h0001);
        chk("ovf_window", bus_if.digits, 16'h2233);
        cyc(1'b1, 1'b0, 8'h00, 1'b0);
        chk("clear_digits", bus_if.digits, 16'h0000);
        chk("clear_ovf", {15'b0, bus_if.overflow}, 16'h0000);

        // clear beats both error and byte on the same edge.
        cyc(1'b0, 1'b1, 8'h9C, 1'b0);
        cyc(1'b1, 1'b1, 8'h77, 1'b1);
        chk("clr_pri_count", {12'b0, bus_if.buf_count}, 16'h0000);
        chk("clr_pri_digits", bus_if.digits, 16'h0000);
        idle(1);
        chk("clr_pri_idle", bus_if.digits, 16'h0000);

        // Reset in the middle of a scroll with overflow set.
        for (int i = 0; i < 5; i++) cyc(1'b0, 1'b1, 8'(8'h18 + 8'(i * 8'h25)), 1'b0);
        idle(3);
        rst_cyc();
        rst_cyc();
        rst_cyc();
        reset = 1'b1;
        #3;
        chk("rst_release_no_edge", bus_if.digits, 16'h0000);
        chk("rst_release_count", {12'b0, bus_if.buf_count}, 16'h0000);
        check_model();

        // Random traffic against the model.
        for (int i = 0; i < 600; i++) begin
            r_c = ($urandom_range(0, 79) == 0);
            r_v = ($urandom_range(0, 3) == 0);
            r_e = ($urandom_range(0, 49) == 0);
            r_d = 8'($urandom);
            cyc(r_c, r_v, r_d, r_e);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
